matmul_sched: RTL and testbench

Two-requester round-robin scheduler that shares one `matmul_top` 2×2 multiply core. It accepts jobs (A, B operand pairs) over per-requester valid/ready ports and latches the winning job's operands. It pulses the core's `start`, waits for `done`, captures C, and returns the result with the requester ID over a single valid/ready response port. It sits between the host-facing request logic and the core.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_sched_if.sv | 35 +++
 rtl/matmul_rr_arb.sv | 39 +++
 rtl/matmul_sched.sv | 146 ++++++++++++++
 tb/tb_matmul_sched.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul scheduler slice: matrix element
// containers, FSM state encoding and the requester-ID width.
package matmul_pkg;

  localparam int MM_DATA_W = 16;
  localparam int MM_ACC_W  = 32;
  localparam int MM_N_REQ  = 2;
  localparam int ID_W      = (MM_N_REQ > 1) ? $clog2(MM_N_REQ) : 1;

  // Elements are two's complement; index as m[row][col].
  typedef logic signed [1:0][1:0][MM_DATA_W-1:0] mat_in_t;
  typedef logic signed [1:0][1:0][MM_ACC_W-1:0]  mat_acc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/matmul_sched_if.sv
// Bundle of the scheduler's request, response and core-side signals.
// The slave modport is the scheduler; the master modport is its environment.
interface matmul_sched_if #(
  parameter int N_REQ  = matmul_pkg::MM_N_REQ,
  parameter int DATA_W = matmul_pkg::MM_DATA_W,
  parameter int ACC_W  = matmul_pkg::MM_ACC_W,
  parameter int ID_W   = matmul_pkg::ID_W
);

  logic [N_REQ-1:0]                          req_valid;
  logic [N_REQ-1:0]                          req_ready;
  logic [N_REQ-1:0][1:0][1:0][DATA_W-1:0]    req_A;
  logic [N_REQ-1:0][1:0][1:0][DATA_W-1:0]    req_B;
  logic                                      rsp_valid;
  logic                                      rsp_ready;
  logic [ID_W-1:0]                           rsp_id;
  logic [1:0][1:0][ACC_W-1:0]                rsp_C;
  logic                                      rsp_err;
  logic                                      core_start;
  logic [1:0][1:0][DATA_W-1:0]               core_A;
  logic [1:0][1:0][DATA_W-1:0]               core_B;
  logic [1:0][1:0][ACC_W-1:0]                core_C;
  logic                                      core_done;

  modport slave (
    input  req_valid, req_A, req_B, rsp_ready, core_C, core_done,
    output req_ready, rsp_valid, rsp_id, rsp_C, rsp_err, core_start, core_A, core_B
  );

  modport master (
    output req_valid, req_A, req_B, rsp_ready, core_C, core_done,
    input  req_ready, rsp_valid, rsp_id, rsp_C, rsp_err, core_start, core_A, core_B
  );

endinterface

// File: rtl/matmul_rr_arb.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod N_REQ)
// and returns a one-hot grant plus its index.
module matmul_rr_arb
  import matmul_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // One spare bit so last_grant + offset cannot overflow before the wrap.
  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand_s;
  logic          hit_s;

  // First valid requester after the previous winner, in rotating order.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s  = {1'b0, last_grant} + CW'(k);
      cand_s  = (cand_s >= CW'(N_REQ)) ? (cand_s - CW'(N_REQ)) : cand_s;
      hit_s   = !gnt_any && req[cand_s[IDX_W-1:0]];
      gnt_idx = hit_s ? cand_s[IDX_W-1:0] : gnt_idx;
      gnt_any = gnt_any | hit_s;
    end
    gnt[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/matmul_sched.sv
// Round-robin job scheduler in front of a shared 2x2 matmul core.
// Optional core timeout: define MATMUL_SCHED_TIMEOUT_EN.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int N_REQ     = 2,
  parameter int TO_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  matmul_sched_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] RESP  = ST_RESP;

  logic [1:0]                  state_r;
  logic [IDX_W-1:0]            last_grant_r;
  logic [IDX_W-1:0]            rsp_id_r;
  logic [1:0][1:0][DATA_W-1:0] core_a_r;
  logic [1:0][1:0][DATA_W-1:0] core_b_r;
  logic [1:0][1:0][ACC_W-1:0]  rsp_c_r;
  logic                        rsp_valid_r;
  logic                        rsp_err_r;
  logic                        core_start_r;
  logic [N_REQ-1:0]            gnt_s;
  logic [IDX_W-1:0]            gnt_idx_s;
  logic                        gnt_any_s;
  logic [N_REQ-1:0]            req_ready_s;
  logic                        accept_s;
  logic                        expire_s;

  matmul_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_r),
    .gnt        (gnt_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s)
  );

  // Ready is only offered in IDLE, and never while reset is being applied.
  always_comb begin
    if (rst_n && (state_r == IDLE)) begin
      req_ready_s = gnt_s;
    end else begin
      req_ready_s = '0;
    end
  end

  assign accept_s = |req_ready_s;

`ifdef MATMUL_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_r;

  // Cycles spent in WAIT; held at zero elsewhere so each WAIT entry starts fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign expire_s = (state_r == WAIT) && (to_cnt_r == TO_W'(TO_CYCLES - 1));
`else
  logic [31:0] to_unused_s;
  assign to_unused_s = 32'(TO_CYCLES);
  assign expire_s    = 1'b0;
`endif

  // Job FSM: latch winner, pulse start, capture result, hold response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDX_W'(N_REQ - 1);
      rsp_id_r     <= '0;
      core_a_r     <= '0;
      core_b_r     <= '0;
      rsp_c_r      <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      core_start_r <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            core_a_r     <= bus.req_A[gnt_idx_s];
            core_b_r     <= bus.req_B[gnt_idx_s];
            rsp_id_r     <= gnt_idx_s;
            last_grant_r <= gnt_idx_s;
            core_start_r <= 1'b1;
            state_r      <= ISSUE;
          end
        end
        ISSUE: state_r <= WAIT;
        WAIT: begin
          // A done arriving on the expiry cycle still counts as a normal result.
          if (bus.core_done) begin
            rsp_c_r     <= bus.core_C;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (expire_s) begin
            rsp_c_r     <= '0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_C      = rsp_c_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.core_start = core_start_r;
  assign bus.core_A     = core_a_r;
  assign bus.core_B     = core_b_r;

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched with a variable-latency core model.
// Build with MATMUL_SCHED_TIMEOUT_EN to exercise the timeout path.
module tb_matmul_sched;
  import matmul_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  matmul_sched_if #(.N_REQ(2), .DATA_W(16), .ACC_W(32), .ID_W(1)) bus ();

  matmul_sched #(
    .DATA_W    (16),
    .ACC_W     (32),
    .N_REQ     (2),
    .TO_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mat_in_t  a_in  [2];
  mat_in_t  b_in  [2];
  mat_acc_t c_exp [2];

  function automatic mat_in_t mk_in(input int a00, input int a01, input int a10, input int a11);
    mat_in_t m;
    m[0][0] = MM_DATA_W'(a00);
    m[0][1] = MM_DATA_W'(a01);
    m[1][0] = MM_DATA_W'(a10);
    m[1][1] = MM_DATA_W'(a11);
    return m;
  endfunction

  function automatic mat_acc_t mk_acc(input int c00, input int c01, input int c10, input int c11);
    mat_acc_t m;
    m[0][0] = MM_ACC_W'(c00);
    m[0][1] = MM_ACC_W'(c01);
    m[1][0] = MM_ACC_W'(c10);
    m[1][1] = MM_ACC_W'(c11);
    return m;
  endfunction

  function automatic mat_acc_t mat_mul(input mat_in_t a, input mat_in_t b);
    mat_acc_t r;
    int p;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        p = int'($signed(a[i][0])) * int'($signed(b[0][j]))
          + int'($signed(a[i][1])) * int'($signed(b[1][j]));
        r[i][j] = MM_ACC_W'(p);
      end
    end
    return r;
  endfunction

  // Core model: done pulses core_lat cycles after the start cycle.
  int       core_cnt  = 0;
  int       core_lat  = 3;
  bit       core_hang = 1'b0;
  mat_acc_t core_c_r;

  always @(posedge clk) begin
    if (bus.core_start && !core_hang) begin
      core_cnt <= core_lat;
      core_c_r <= mat_mul(bus.core_A, bus.core_B);
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign bus.core_done = (core_cnt == 1);
  assign bus.core_C    = core_c_r;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_req_ready"},  bus.req_ready, 2'b00);
    check({tag, "_rsp_valid"},  bus.rsp_valid, 1'b0);
    check({tag, "_rsp_err"},    bus.rsp_err, 1'b0);
    check({tag, "_core_start"}, bus.core_start, 1'b0);
    check({tag, "_rsp_id"},     bus.rsp_id, 1'b0);
    check({tag, "_rsp_c"},      bus.rsp_C, 128'd0);
    check({tag, "_core_a"},     bus.core_A, 64'd0);
    check({tag, "_core_b"},     bus.core_B, 64'd0);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no req_ready expected a grant within 20 cycles");
    end
  endtask

  // Returns the cycle (accept = 0) at which rsp_valid is first seen, or -1.
  task automatic wait_rsp(input int start_cyc, output int cyc);
    cyc = -1;
    for (int n = start_cyc + 1; n < start_cyc + 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic run_job(input logic [1:0] mask, input logic [1:0] nxt, input int lat,
                         input int id, input int exp_cyc, input bit exp_err);
    bit       ok;
    int       cyc;
    mat_acc_t ec;
    core_lat      = lat;
    bus.req_valid = mask;
    wait_grant(ok);
    if (ok) begin
      check("grant", bus.req_ready, 2'b01 << id);
      @(posedge clk);
      #1;
      bus.req_valid = nxt;
      @(negedge clk);
      check("core_start", bus.core_start, 1'b1);
      check("core_a", bus.core_A, $unsigned(a_in[id]));
      check("core_b", bus.core_B, $unsigned(b_in[id]));
      wait_rsp(1, cyc);
      check("rsp_latency", cyc, exp_cyc);
      check("rsp_id", bus.rsp_id, id);
      check("rsp_err", bus.rsp_err, exp_err);
      ec = exp_err ? mat_acc_t'('0) : c_exp[id];
      check("rsp_c", bus.rsp_C, $unsigned(ec));
      @(posedge clk);
      #1;
    end else begin
      bus.req_valid = nxt;
    end
  endtask

  typedef struct {
    logic [1:0] mask;
    logic [1:0] nxt;
    int         lat;
    int         id;
    int         cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit ok;
    int cyc;
    int cnt;

    a_in[0]  = mk_in(1, 2, 3, 4);
    b_in[0]  = mk_in(5, 6, 7, 8);
    c_exp[0] = mk_acc(19, 22, 43, 50);
    a_in[1]  = mk_in(-1, 0, 2, 3);
    b_in[1]  = mk_in(4, -2, 1, 5);
    c_exp[1] = mk_acc(-4, 2, 11, 11);

    // mask, next mask, core latency, expected id, accept-to-rsp_valid cycles
    vecs[0] = '{2'b01, 2'b11, 3, 0, 5};
    vecs[1] = '{2'b11, 2'b11, 3, 1, 5};
    vecs[2] = '{2'b11, 2'b11, 1, 0, 3};
    vecs[3] = '{2'b11, 2'b10, 4, 1, 6};
    vecs[4] = '{2'b10, 2'b10, 3, 1, 5};
    vecs[5] = '{2'b10, 2'b01, 2, 1, 4};
    vecs[6] = '{2'b01, 2'b01, 3, 0, 5};
    vecs[7] = '{2'b01, 2'b00, 3, 0, 5};

    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    bus.req_A[0]  = a_in[0];
    bus.req_B[0]  = b_in[0];
    bus.req_A[1]  = a_in[1];
    bus.req_B[1]  = b_in[1];
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].mask, vecs[i].nxt, vecs[i].lat, vecs[i].id, vecs[i].cyc, 1'b0);
    end

    // Response back-pressure: rsp held, no new grants while stalled.
    core_lat      = 3;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    wait_grant(ok);
    check("stall_grant", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    wait_rsp(1, cyc);
    check("stall_latency", cyc, 5);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", bus.rsp_valid, 1'b1);
      check("stall_c", bus.rsp_C, $unsigned(c_exp[0]));
      check("stall_req_ready", bus.req_ready, 2'b00);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    check("stall_release_valid", bus.rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    run_job(2'b11, 2'b00, 3, 1, 5, 1'b0);

    // Reset during WAIT: everything cleared, late done ignored, req 0 wins next.
    core_lat      = 10;
    bus.req_valid = 2'b01;
    wait_grant(ok);
    check("rstwait_grant", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_wait");
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.core_start) cnt++;
    end
    check("late_done_ignored", cnt, 0);
    @(posedge clk);
    #1;
    run_job(2'b11, 2'b00, 3, 0, 5, 1'b0);

    // Core that never finishes.
    core_hang = 1'b1;
`ifdef MATMUL_SCHED_TIMEOUT_EN
    run_job(2'b01, 2'b00, 3, 0, 10, 1'b1);
`else
    bus.req_valid = 2'b01;
    wait_grant(ok);
    check("hang_grant", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    wait_rsp(1, cyc);
    check("hang_no_rsp", (cyc < 0), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif
    core_hang = 1'b0;

    // Done lands exactly on the would-be expiry cycle: normal result.
    run_job(2'b10, 2'b00, 8, 1, 10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
